// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA raster constants, coordinate/colour types and quadrant codes.
package vga_pkg;

  // Default 640x480@60 timing with a 25 MHz pixel rate from a 50 MHz system clock.
  localparam int unsigned VGA_CLK_DIV  = 2;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam bit          VGA_SYNC_POL = 1'b0;

  localparam int unsigned VGA_COORD_MAX = 1024;

  function automatic int unsigned vga_total(input int unsigned sync_w, input int unsigned bp,
                                            input int unsigned active, input int unsigned fp);
    return sync_w + bp + active + fp;
  endfunction

  localparam int unsigned VGA_H_TOTAL = vga_total(VGA_H_SYNC, VGA_H_BP, VGA_H_ACTIVE, VGA_H_FP);
  localparam int unsigned VGA_V_TOTAL = vga_total(VGA_V_SYNC, VGA_V_BP, VGA_V_ACTIVE, VGA_V_FP);

  typedef logic [9:0]  coord_t;
  typedef logic [23:0] rgb_t;

  localparam logic [2:0] QUAD_TL = 3'b001;
  localparam logic [2:0] QUAD_TR = 3'b010;
  localparam logic [2:0] QUAD_BL = 3'b011;
  localparam logic [2:0] QUAD_BR = 3'b100;

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from the generator to the pixel pipeline.
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_if;
  import vga_pkg::*;

  logic   pix_tick;
  coord_t hcount;
  coord_t vcount;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

`ifdef VGA_TIMING_FRAME_CNT_EN
  modport master (output pix_tick, hcount, vcount, hsync, vsync, video_on, frame_start, frame_cnt);
  modport slave  (input  pix_tick, hcount, vcount, hsync, vsync, video_on, frame_start, frame_cnt);
`else
  modport master (output pix_tick, hcount, vcount, hsync, vsync, video_on, frame_start);
  modport slave  (input  pix_tick, hcount, vcount, hsync, vsync, video_on, frame_start);
`endif

endinterface

// File: rtl/vga_timing_gen_pix_tick_gen.sv
// rtl/vga_timing_gen_pix_tick_gen.sv - divides the system clock into a one-clk pixel-enable pulse.
module pix_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick_o
);

  localparam int unsigned      CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("pix_tick_gen: CLK_DIV must be >= 1");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign pix_tick_o = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA h/v counters, decoded sync/active-video and frame-start strobe.
// Define VGA_TIMING_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter bit          SYNC_POL = VGA_SYNC_POL
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL     = vga_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int unsigned V_TOTAL     = vga_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int unsigned H_VIS_START = H_SYNC + H_BP;
  localparam int unsigned H_VIS_END   = H_VIS_START + H_ACTIVE;
  localparam int unsigned V_VIS_START = V_SYNC + V_BP;
  localparam int unsigned V_VIS_END   = V_VIS_START + V_ACTIVE;

  generate
    if (H_TOTAL > VGA_COORD_MAX || V_TOTAL > VGA_COORD_MAX) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  logic   pix_tick;
  coord_t hcount_q, hcount_d;
  coord_t vcount_q, vcount_d;
  logic   frame_start_q, frame_start_d;
  logic   at_h_end, at_v_end;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_tick_o (pix_tick)
  );

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    at_h_end      = (hcount_q == coord_t'(H_TOTAL - 1));
    at_v_end      = (vcount_q == coord_t'(V_TOTAL - 1));
    if (pix_tick) begin
      if (at_h_end) begin
        hcount_d      = '0;
        vcount_d      = at_v_end ? '0 : vcount_q + coord_t'(1);
        frame_start_d = at_v_end;
      end else begin
        hcount_d = hcount_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_start_q <= frame_start_d;
    end
  end

  // One extra bit so a window ending exactly at 1024 still compares correctly.
  logic [10:0] hpos, vpos;
  assign hpos = {1'b0, hcount_q};
  assign vpos = {1'b0, vcount_q};

  assign vga.pix_tick    = pix_tick;
  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.frame_start = frame_start_q;
  assign vga.hsync       = (hpos < 11'(H_SYNC)) ? SYNC_POL : ~SYNC_POL;
  assign vga.vsync       = (vpos < 11'(V_SYNC)) ? SYNC_POL : ~SYNC_POL;
  assign vga.video_on    = (hpos >= 11'(H_VIS_START)) && (hpos < 11'(H_VIS_END)) &&
                           (vpos >= 11'(V_VIS_START)) && (vpos < 11'(V_VIS_END));

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'd0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (frame_cnt checks under VGA_TIMING_FRAME_CNT_EN).
module tb_vga_timing_gen;

  // Default horizontal timing, shortened vertical timing so several frames fit the run.
  localparam int HT    = 800;
  localparam int HS    = 96;
  localparam int HBP   = 48;
  localparam int HACT  = 640;
  localparam int VS    = 2;
  localparam int VBP   = 2;
  localparam int VACT  = 2;
  localparam int VT    = 7;
  localparam int FRAME = HT * VT;
  localparam int RUN   = 33700;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vga_timing_if v1 ();
  vga_timing_if v2 ();

  vga_timing_gen #(
    .CLK_DIV(2), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HACT), .H_FP(16),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VACT), .V_FP(1), .SYNC_POL(1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (v1)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HACT), .H_FP(16),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VACT), .V_FP(1), .SYNC_POL(1'b1)
  ) dut_div1 (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (v2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {pix_tick, hcount, vcount, hsync, vsync, video_on, frame_start} after clock edge n
  // counted from reset release, in closed form from the edge count.
  function automatic logic [24:0] exp_raster(input int n, input int d, input bit pol);
    int p, h, v;
    bit tick, adv, fs, hs, vs, von;
    p    = (n >= 1) ? (n - 1) / d : 0;
    tick = (n >= d) && (n % d == 0);
    adv  = (n >= 2) && (((n - 1) / d) > ((n - 2) / d));
    h    = p % HT;
    v    = (p / HT) % VT;
    fs   = adv && (p > 0) && (p % FRAME == 0);
    hs   = (h < HS) ? pol : !pol;
    vs   = (v < VS) ? pol : !pol;
    von  = (h >= HS + HBP) && (h < HS + HBP + HACT) && (v >= VS + VBP) && (v < VS + VBP + VACT);
    return {tick, h[9:0], v[9:0], hs, vs, von, fs};
  endfunction

  logic [24:0] obs1, obs2;
  assign obs1 = {v1.pix_tick, v1.hcount, v1.vcount, v1.hsync, v1.vsync, v1.video_on, v1.frame_start};
  assign obs2 = {v2.pix_tick, v2.hcount, v2.vcount, v2.hsync, v2.vsync, v2.video_on, v2.frame_start};

  int          n_edge = 0;
  logic [24:0] sb1[$];
  logic [24:0] sb2[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      n_edge <= 0;
    end else begin
      sb1.push_back(exp_raster(n_edge + 1, 2, 1'b0));
      sb2.push_back(exp_raster(n_edge + 1, 1, 1'b1));
      n_edge <= n_edge + 1;
    end
  end

  always @(negedge clk) begin
    if (sb1.size() > 0) check_eq("raster_div2", 32'(obs1), 32'(sb1.pop_front()));
    if (sb2.size() > 0) check_eq("raster_div1", 32'(obs2), 32'(sb2.pop_front()));
  end

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_hcount"},   32'(v1.hcount), 0);
    check_eq({tag, "_vcount"},   32'(v1.vcount), 0);
    check_eq({tag, "_hsync"},    32'(v1.hsync), 0);
    check_eq({tag, "_vsync"},    32'(v1.vsync), 0);
    check_eq({tag, "_video_on"}, 32'(v1.video_on), 0);
    check_eq({tag, "_fstart"},   32'(v1.frame_start), 0);
    check_eq({tag, "_tick"},     32'(v1.pix_tick), 0);
    check_eq({tag, "_hsync_p1"}, 32'(v2.hsync), 1);
    check_eq({tag, "_vsync_p1"}, 32'(v2.vsync), 1);
  endtask

  initial begin
    int t1, t2, found;
    int hs_low1, vs_low1, tick1, tick2, hs_high2;
    int fs_cnt, last_fs, rises, falls, rise_h, rise_v;
    logic prev_von;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");
    #2 rst_n = 1'b1;

    t1 = 0;
    t2 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (t1 == 0 && v1.pix_tick) t1 = k;
      if (t2 == 0 && v2.pix_tick) t2 = k;
    end
    check_eq("tick_latency_div2", t1, 2);
    check_eq("tick_latency_div1", t2, 1);

    found = 0;
    for (int k = 0; k < 2000 && found == 0; k++) begin
      @(negedge clk);
      if (v1.hcount == 10'd300) found = 1;
    end
    check_eq("reach_h300", found, 1);

    // Asynchronous reset mid-line, sampled before any further clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("async");
    @(negedge clk);
    #2 rst_n = 1'b1;

    hs_low1 = 0; vs_low1 = 0; tick1 = 0; tick2 = 0; hs_high2 = 0;
    fs_cnt = 0; last_fs = 0; rises = 0; falls = 0; rise_h = -1; rise_v = -1;
    prev_von = 1'b0;
    for (int i = 1; i <= RUN; i++) begin
      @(negedge clk);
      if (i <= 2 * HT) begin
        if (!v1.hsync)   hs_low1++;
        if (v1.pix_tick) tick1++;
      end
      if (i <= 2 * FRAME && !v1.vsync) vs_low1++;
      if (i <= HT) begin
        if (v2.pix_tick) tick2++;
        if (v2.hsync)    hs_high2++;
      end
      if (v1.video_on && !prev_von) begin
        if (rises == 0) begin
          rise_h = int'(v1.hcount);
          rise_v = int'(v1.vcount);
        end
        rises++;
      end
      if (!v1.video_on && prev_von) begin
        check_eq("von_fall_h", 32'(v1.hcount), 784);
        falls++;
      end
      prev_von = v1.video_on;
      if (v1.frame_start) begin
        check_eq("fstart_at_origin", {v1.hcount, v1.vcount}, 0);
        if (last_fs > 0) check_eq("fstart_period", i - last_fs, 2 * FRAME);
        last_fs = i;
        fs_cnt++;
      end
    end

    check_eq("hsync_low_per_line", hs_low1, 192);
    check_eq("ticks_per_line_div2", tick1, HT);
    check_eq("vsync_low_per_frame", vs_low1, 3200);
    check_eq("ticks_div1", tick2, HT);
    check_eq("hsync_high_div1", hs_high2, HS);
    check_eq("von_rise_h", rise_h, 144);
    check_eq("von_rise_v", rise_v, VS + VBP);
    check_eq("von_rises", rises, 3 * VACT);
    check_eq("von_falls", falls, 3 * VACT);
    check_eq("fstart_count", fs_cnt, 3);

`ifdef VGA_TIMING_FRAME_CNT_EN
    check_eq("frame_cnt_3", 32'(v1.frame_cnt), 3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("frame_cnt_reset", 32'(v1.frame_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
